// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding,
// stall counter width and a saturating increment helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int STALL_BITS = 16;
    localparam logic [STALL_BITS-1:0] STALL_MAX = '1;

    function automatic logic [STALL_BITS-1:0] sat_inc(input logic [STALL_BITS-1:0] value);
        return (value == STALL_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_payload_slot.sv
// One payload register with synchronous clear and load; clear wins over load
// so a flushed or drained slot always reads back as zero.
module pipe_payload_slot
    import pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register. Define PIPE_STAGE_SKID_EN for the
// two-entry skid build with a fully registered in_ready; otherwise single entry.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PC_BITS   = 32,
    parameter int IR_BITS   = 32,
    parameter int CTRL_BITS = 16,
    parameter int DATA_BITS = 32,
    parameter int LANES     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_BITS-1:0]         in_pc,
    input  logic [IR_BITS-1:0]         in_ir,
    input  logic [CTRL_BITS-1:0]       in_ctrl,
    input  logic [LANES*DATA_BITS-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_BITS-1:0]         out_pc,
    output logic [IR_BITS-1:0]         out_ir,
    output logic [CTRL_BITS-1:0]       out_ctrl,
    output logic [LANES*DATA_BITS-1:0] out_data,
    output logic [STALL_BITS-1:0]      stall_cnt
);

    localparam int DW = LANES * DATA_BITS;
    localparam int PW = PC_BITS + IR_BITS + CTRL_BITS + DW;

    state_t        state;
    logic          out_valid_r;
    logic          accept;
    logic          drain;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] main_d;
    logic [PW-1:0] main_q;
    logic          main_load;
    logic          main_clear;

    assign in_payload = {in_pc, in_ir, in_ctrl, in_data};
    assign accept     = in_valid && in_ready && !flush;
    assign drain      = out_valid && out_ready;
    assign out_valid  = out_valid_r;

    // The main slot is cleared whenever it empties, so the outputs are zero while idle.
    assign {out_pc, out_ir, out_ctrl, out_data} = main_q;

`ifdef PIPE_STAGE_SKID_EN
    logic          in_ready_r;
    logic [PW-1:0] skid_q;
    logic          skid_load;
    logic          skid_clear;

    assign in_ready = in_ready_r;

    always_comb begin
        main_d     = in_payload;
        main_load  = 1'b0;
        main_clear = flush;
        skid_load  = 1'b0;
        skid_clear = flush;
        if (!flush) begin
            case (state)
                EMPTY: main_load = accept;
                ONE: begin
                    if (accept && drain) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                    end else if (drain) begin
                        main_clear = 1'b1;
                    end
                end
                TWO: begin
                    if (drain) begin
                        main_d     = skid_q;
                        main_load  = 1'b1;
                        skid_clear = 1'b1;
                    end
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    // in_ready and out_valid are updated alongside the state so neither has a combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else if (flush) begin
            state       <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state       <= ONE;
                        out_valid_r <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !drain) begin
                        state      <= TWO;
                        in_ready_r <= 1'b0;
                    end else if (drain && !accept) begin
                        state       <= EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state      <= ONE;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    pipe_payload_slot #(.WIDTH(PW)) skid (
        .clk   (clk),
        .rst   (rst),
        .clear (skid_clear),
        .load  (skid_load),
        .d     (in_payload),
        .q     (skid_q)
    );
`else
    assign in_ready = !out_valid || out_ready;

    always_comb begin
        main_d     = in_payload;
        main_load  = accept;
        main_clear = flush || (drain && !accept);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            out_valid_r <= 1'b0;
        end else if (flush) begin
            state       <= EMPTY;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state       <= ONE;
                        out_valid_r <= 1'b1;
                    end
                end
                ONE: begin
                    if (drain && !accept) begin
                        state       <= EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
`endif

    pipe_payload_slot #(.WIDTH(PW)) main (
        .clk   (clk),
        .rst   (rst),
        .clear (main_clear),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    // Flush freezes the counter; only reset returns it to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!flush && out_valid && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [31:0]  pc;
        logic [31:0]  ir;
        logic [15:0]  ctrl;
        logic [127:0] data;
    } pay_t;

    typedef struct {
        bit          iv;
        bit          ordy;
        logic [31:0] pc;
        bit          e_ov;
        bit          e_ir;
        logic [31:0] e_pc;
        logic [15:0] e_stall;
    } vec_t;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_pc;
    logic [31:0]  in_ir;
    logic [15:0]  in_ctrl;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_pc;
    logic [31:0]  out_ir;
    logic [15:0]  out_ctrl;
    logic [127:0] out_data;
    logic [15:0]  stall_cnt;

    logic         b_flush, b_iv, b_or;
    logic [31:0]  b_pc, b_ir;
    logic [15:0]  b_ctrl;
    logic [31:0]  b_data1;
    logic [255:0] b_data8;
    logic         u1_in_ready, u1_out_valid, u8_in_ready, u8_out_valid;
    logic [31:0]  u1_out_pc, u1_out_ir, u8_out_pc, u8_out_ir;
    logic [15:0]  u1_out_ctrl, u8_out_ctrl, u1_stall, u8_stall;
    logic [31:0]  u1_out_data;
    logic [255:0] u8_out_data;

    int           checks = 0;
    int           errors = 0;
    pay_t         mq[$];
    logic [15:0]  mcnt;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_ir(in_ir), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ir(out_ir), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.LANES(1)) u1 (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_iv), .in_ready(u1_in_ready),
        .in_pc(b_pc), .in_ir(b_ir), .in_ctrl(b_ctrl), .in_data(b_data1),
        .out_valid(u1_out_valid), .out_ready(b_or),
        .out_pc(u1_out_pc), .out_ir(u1_out_ir), .out_ctrl(u1_out_ctrl), .out_data(u1_out_data),
        .stall_cnt(u1_stall)
    );

    pipe_stage_reg #(.LANES(8)) u8 (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_iv), .in_ready(u8_in_ready),
        .in_pc(b_pc), .in_ir(b_ir), .in_ctrl(b_ctrl), .in_data(b_data8),
        .out_valid(u8_out_valid), .out_ready(b_or),
        .out_pc(u8_out_pc), .out_ir(u8_out_ir), .out_ctrl(u8_out_ctrl), .out_data(u8_out_data),
        .stall_cnt(u8_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic pay_t mkpay(input logic [31:0] pc);
        pay_t p;
        p.pc   = pc;
        p.ir   = ~pc;
        p.ctrl = pc[15:0] ^ 16'h5a5a;
        p.data = {pc + 32'd3, pc + 32'd2, pc + 32'd1, pc};
        return p;
    endfunction

    // Reference: a FIFO of capacity 2 (skid) or 1 (single entry).
    function automatic bit model_ready();
        if (SKID) return mq.size() < 2;
        return (mq.size() == 0) || (out_ready == 1'b1);
    endfunction

    task automatic applyStimulus(input bit iv, input bit ordy, input bit fl, input pay_t p);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_pc     = p.pc;
        in_ir     = p.ir;
        in_ctrl   = p.ctrl;
        in_data   = p.data;
        #1;
    endtask

    task automatic checkOutput();
        pay_t e;
        e = (mq.size() > 0) ? mq[0] : '0;
        chk("out_valid", 256'(out_valid), 256'(mq.size() > 0));
        chk("in_ready", 256'(in_ready), 256'(model_ready()));
        chk("out_pc", 256'(out_pc), 256'(e.pc));
        chk("out_ir", 256'(out_ir), 256'(e.ir));
        chk("out_ctrl", 256'(out_ctrl), 256'(e.ctrl));
        chk("out_data", 256'(out_data), 256'(e.data));
        chk("stall_cnt", 256'(stall_cnt), 256'(mcnt));
    endtask

    task automatic tick();
        bit   rdy;
        bit   stalled;
        pay_t p;
        rdy     = model_ready();
        stalled = !flush && (mq.size() > 0) && !out_ready;
        p       = {in_pc, in_ir, in_ctrl, in_data};
        if (flush) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && rdy) mq.push_back(p);
        end
        if (stalled && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        b_iv = 1'b0;
        b_or = 1'b0;
        mq.delete();
        mcnt = '0;
        @(posedge clk);
        #1;
        chk("reset out_valid", 256'(out_valid), 256'(0));
        chk("reset in_ready", 256'(in_ready), 256'(1));
        chk("reset out_data", 256'(out_data), 256'(0));
        chk("reset stall_cnt", 256'(stall_cnt), 256'(0));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vec_t        tbl[9];
        pay_t        p, e;
        logic [15:0] saved;
        logic [31:0] prev1;
        logic [255:0] prev8;
        logic [31:0] a_pc, b_pc_v, c_pc;

        rst = 1'b1;
        b_flush = 1'b0; b_iv = 1'b0; b_or = 1'b0;
        b_pc = '0; b_ir = '0; b_ctrl = '0; b_data1 = '0; b_data8 = '0;
        a_pc = 32'h0000_0A00; b_pc_v = 32'h0000_0B00; c_pc = 32'h0000_0C00;

        tbl[0] = '{1, 1, 32'h0040_0000, 0, 1, 0, 0};
        tbl[1] = '{0, 1, 0, 1, 1, 32'h0040_0000, 0};
        tbl[2] = '{1, 0, a_pc, 0, 1, 0, 0};
`ifdef PIPE_STAGE_SKID_EN
        tbl[3] = '{1, 0, b_pc_v, 1, 1, a_pc, 0};
        tbl[4] = '{1, 0, c_pc, 1, 0, a_pc, 1};
        tbl[5] = '{1, 1, c_pc, 1, 0, a_pc, 2};
        tbl[6] = '{1, 1, c_pc, 1, 1, b_pc_v, 2};
        tbl[7] = '{0, 1, 0, 1, 1, c_pc, 2};
        tbl[8] = '{0, 1, 0, 0, 1, 0, 2};
`else
        tbl[3] = '{1, 0, b_pc_v, 1, 0, a_pc, 0};
        tbl[4] = '{1, 1, b_pc_v, 1, 1, a_pc, 1};
        tbl[5] = '{1, 1, c_pc, 1, 1, b_pc_v, 1};
        tbl[6] = '{0, 1, 0, 1, 1, c_pc, 1};
        tbl[7] = '{0, 1, 0, 0, 1, 0, 1};
        tbl[8] = '{0, 0, 0, 0, 1, 0, 1};
`endif

        doReset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i].iv, tbl[i].ordy, 1'b0, tbl[i].iv ? mkpay(tbl[i].pc) : '0);
            checkOutput();
            e = (tbl[i].e_pc == 0) ? '0 : mkpay(tbl[i].e_pc);
            chk($sformatf("tbl%0d out_valid", i), 256'(out_valid), 256'(tbl[i].e_ov));
            chk($sformatf("tbl%0d in_ready", i), 256'(in_ready), 256'(tbl[i].e_ir));
            chk($sformatf("tbl%0d payload", i), 256'({out_pc, out_ir, out_ctrl, out_data}), 256'(e));
            chk($sformatf("tbl%0d stall_cnt", i), 256'(stall_cnt), 256'(tbl[i].e_stall));
            tick();
        end

        // Flush while full (TWO in the skid build), with a new input offered.
        applyStimulus(1'b1, 1'b0, 1'b0, mkpay(32'h0000_0D00)); checkOutput(); tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mkpay(32'h0000_0E00)); checkOutput(); tick();
        saved = mcnt;
        applyStimulus(1'b1, 1'b0, 1'b1, mkpay(32'h0000_0F00)); checkOutput(); tick();
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput();
        chk("flush out_valid", 256'(out_valid), 256'(0));
        chk("flush fields", 256'({out_pc, out_ir, out_ctrl, out_data}), 256'(0));
        chk("flush stall_cnt", 256'(stall_cnt), 256'(saved));
        for (int i = 0; i < 3; i++) begin
            tick();
            applyStimulus(1'b0, 1'b1, 1'b0, '0);
            chk("flushed input never emitted", 256'(out_valid), 256'(0));
        end
        tick();

        // Flush with in_ready high must still discard the offered input.
        applyStimulus(1'b1, 1'b0, 1'b0, mkpay(32'h0000_1100)); checkOutput(); tick();
        applyStimulus(1'b1, 1'b1, 1'b1, mkpay(32'h0000_1200)); checkOutput();
        chk("flush cycle in_ready", 256'(in_ready), 256'(1));
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, '0); checkOutput();
        chk("flush ONE out_valid", 256'(out_valid), 256'(0));
        tick();

        // Asynchronous reset between edges while holding one entry.
        applyStimulus(1'b1, 1'b0, 1'b0, mkpay(32'h0000_1300)); checkOutput(); tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        chk("pre-reset out_valid", 256'(out_valid), 256'(1));
        #1;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 256'(out_valid), 256'(0));
        chk("async rst out_data", 256'(out_data), 256'(0));
        chk("async rst in_ready", 256'(in_ready), 256'(1));
        chk("async rst stall_cnt", 256'(stall_cnt), 256'(0));
        mq.delete();
        mcnt = '0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, mkpay(32'h0000_1400)); checkOutput(); tick();
        applyStimulus(1'b0, 1'b1, 1'b0, '0); checkOutput();
        chk("first accept after reset", 256'(out_pc), 256'(32'h0000_1400));
        tick();

        // Long back-pressure saturates the stall counter.
        applyStimulus(1'b1, 1'b0, 1'b0, mkpay(32'h0000_1500)); checkOutput(); tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 70000; i++) tick();
        checkOutput();
        chk("stall saturated", 256'(stall_cnt), 256'(16'hFFFF));
        for (int i = 0; i < 5; i++) tick();
        checkOutput();
        chk("stall stays saturated", 256'(stall_cnt), 256'(16'hFFFF));
        chk("stalled entry held", 256'(out_pc), 256'(32'h0000_1500));

        // Back-to-back throughput on the LANES=1 and LANES=8 instances.
        doReset();
        b_or = 1'b1;
        prev1 = '0;
        prev8 = '0;
        for (int i = 0; i < 12; i++) begin
            b_iv    = 1'b1;
            b_pc    = 32'(i + 1);
            b_ir    = $urandom;
            b_ctrl  = 16'($urandom);
            b_data1 = $urandom;
            b_data8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            #1;
            chk("u1 in_ready", 256'(u1_in_ready), 256'(1));
            chk("u8 in_ready", 256'(u8_in_ready), 256'(1));
            if (i > 0) begin
                chk("u1 out_valid", 256'(u1_out_valid), 256'(1));
                chk("u1 out_pc", 256'(u1_out_pc), 256'(i));
                chk("u1 out_data", 256'(u1_out_data), 256'(prev1));
                chk("u8 out_valid", 256'(u8_out_valid), 256'(1));
                chk("u8 out_data", 256'(u8_out_data), prev8);
            end
            prev1 = b_data1;
            prev8 = b_data8;
            @(posedge clk);
            #1;
        end
        b_iv = 1'b0;
        #1;
        chk("u8 last out_data", 256'(u8_out_data), prev8);
        @(posedge clk);
        #1;
        chk("u1 drained", 256'(u1_out_valid), 256'(0));
        chk("u8 drained data", 256'(u8_out_data), 256'(0));
        chk("u1 stall_cnt", 256'(u1_stall), 256'(0));

        // Randomized traffic against the queue model.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            p.pc   = $urandom;
            p.ir   = $urandom;
            p.ctrl = 16'($urandom);
            p.data = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 31) == 0), p);
            checkOutput();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter PC_BITS, default 32, program-counter field width.
REQ-002 SHALL have parameter IR_BITS, default 32, instruction field width.
REQ-003 SHALL have parameter CTRL_BITS, default 16, packed control-bundle width (RegWrite, MemWrite, MemToReg and similar).
REQ-004 SHALL have parameter DATA_BITS, default 32, width of one data lane.
REQ-005 SHALL have parameter LANES, default 4, number of data lanes (result_1, result_2, lo, hi), range 1..8.
REQ-006 SHALL have one clock; reset is asynchronous and active-high; clock port clk, reset port rst.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 flush  in  1  synchronous kill of all held entries and of any input offered this cycle.
REQ-010 in_valid  in  1  upstream stage offers a payload.
REQ-011 in_ready  out  1  this stage accepts a payload this cycle.
REQ-012 in_pc / in_ir / in_ctrl  in  PC_BITS / IR_BITS / CTRL_BITS  upstream fields.
REQ-013 in_data  in  LANES*DATA_BITS  lane k at bits [k*DATA_BITS +: DATA_BITS].
REQ-014 out_valid  out  1  payload presented downstream.
REQ-015 out_ready  in  1  downstream accepts the payload.
REQ-016 out_pc / out_ir / out_ctrl / out_data  out  same widths as inputs  presented payload.
REQ-017 stall_cnt  out  16  saturating count of back-pressure cycles.

Function
REQ-018 A transfer SHALL occur on each rising edge where valid and ready are both high on that side; a payload SHALL NOT be lost, duplicated or reordered.
REQ-019 Latency SHALL be exactly 1 cycle from input acceptance to out_valid when the stage is empty.
REQ-020 With the skid buffer compiled in, the state machine SHALL be EMPTY (no entry), ONE (main entry valid), TWO (main and skid valid).
REQ-021 EMPTY->ONE on accept.
REQ-022 ONE->TWO on accept without drain.
REQ-023 ONE->EMPTY on drain without accept.
REQ-024 ONE stays ONE on simultaneous accept and drain, with main reloaded.
REQ-025 TWO->ONE on drain; the skid entry moves to main in the same edge.
REQ-026 in_ready SHALL be a register output equal to (state != TWO).
REQ-027 out_valid SHALL be a register output equal to (state != EMPTY).
REQ-028 Any field of out_* SHALL be all-zero whenever out_valid is low.
REQ-029 flush SHALL have priority over every other event: the next state is EMPTY, all payload registers are zeroed, and an input offered in the flush cycle is discarded even if in_ready is high.
REQ-030 stall_cnt SHALL increment by 1 on each cycle with out_valid high and out_ready low, and saturate at 16'hFFFF.
REQ-031 stall_cnt SHALL hold its value on flush and clear only on reset.

Reset
REQ-032 Asserting rst SHALL immediately (without a clock edge) force state EMPTY, out_valid=0, all out_* fields=0 and stall_cnt=0.
REQ-033 Asserting rst SHALL force in_ready=1 in both build configurations.
REQ-034 Reset asserted mid-transfer SHALL discard every held entry.
REQ-035 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-036 Macro PIPE_STAGE_SKID_EN defined: the two-entry skid behaviour of REQ-020..REQ-026 applies, and in_ready has no combinational path from out_ready.
REQ-037 Macro PIPE_STAGE_SKID_EN undefined: the stage holds a single entry (states EMPTY and ONE only); in_ready = !out_valid || out_ready, combinationally; REQ-019 and REQ-027..REQ-031 are unchanged.

Structure
REQ-038 A shared package pipe_pkg SHALL hold the state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the stall_cnt width constant (16).
REQ-039 One sub-module, pipe_payload_slot, SHALL implement a single clear/load payload register; it is instantiated as main and, under the macro, as skid.

Verification
REQ-040 Scenario SHALL cover: reset, then in_valid=1 with in_pc=32'h0040_0000 and out_ready=1 -> out_valid=1 with out_pc=32'h0040_0000 exactly 1 cycle later.
REQ-041 Scenario SHALL cover (skid build): hold out_ready=0 and offer 3 payloads A, B, C -> A and B accepted, in_ready=0, C held upstream; then raise out_ready -> outputs A, B, C in order with no gaps.
REQ-042 Scenario SHALL cover: state TWO with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, all out_* fields=0, the offered input is never emitted, and stall_cnt is unchanged.
REQ-043 Scenario SHALL cover: out_valid=1 with out_ready=0 for 70000 cycles -> stall_cnt reads 16'hFFFF and stays there.
REQ-044 Scenario SHALL cover: assert rst asynchronously between edges while in state ONE -> out_valid falls before the next edge and out_data=0.
REQ-045 Scenario SHALL cover (non-skid build): out_valid=1, out_ready=1, in_valid=1 -> in_ready=1 in the same cycle, back-to-back throughput of 1 payload per cycle, LANES=1 and LANES=8 both exercised.
